// File: rtl/seg_scan_capture.sv
// seg_scan_capture: watches a multiplexed active-low anode/segment bus and
// recovers the hex value shown on each digit, with blank/illegal/multi-anode
// detection and a pulse each time every digit has been seen once.
module seg_scan_capture #(
    parameter int NDIG   = 4,
    parameter int SETTLE = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NDIG-1:0]     an,
    input  logic [6:0]          seg,
    input  logic                clr,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     valid,
    output logic [NDIG-1:0]     blank,
    output logic                frame_done,
    output logic                bad_pat,
    output logic                err
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

    logic [NDIG-1:0] an_sync_reg;
    logic [6:0]      seg_sync_reg;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            sampled_reg, sampled_next;
    logic            match;
    logic            fire;
    logic [7:0]      zero_cnt;
    logic            one_hot;
    logic            multi_hot;
    logic            take;
    logic [3:0]      glyph_val;
    logic            glyph_ok;
    logic            is_blank;
    logic [NDIG-1:0] seen_reg;
    logic [NDIG-1:0] seen_or;
    logic [3:0]      digit_reg [NDIG];
    logic [NDIG-1:0] valid_reg;
    logic [NDIG-1:0] blank_reg;
    logic            frame_done_reg;
    logic            bad_pat_reg;
    logic            err_reg;

    // Input stage: bus registered once; resets to the idle (all off) state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_sync_reg  <= '1;
            seg_sync_reg <= 7'h7F;
        end else begin
            an_sync_reg  <= an;
            seg_sync_reg <= seg;
        end
    end

    // Dwell tracking: the value about to be registered is compared with the
    // one already held, so a value present before edge E samples at E+SETTLE.
    always_comb begin
        match        = ({an, seg} == {an_sync_reg, seg_sync_reg});
        cnt_next     = '0;
        sampled_next = 1'b0;
        fire         = 1'b0;
        if (match) begin
            cnt_next     = (cnt_reg == SETTLE_C) ? SETTLE_C : cnt_reg + 1'b1;
            fire         = (cnt_next == SETTLE_C) && !sampled_reg;
            sampled_next = sampled_reg || fire;
        end
    end

    // Dwell counter and one-sample-per-dwell flag (unaffected by clr).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            sampled_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            sampled_reg <= sampled_next;
        end
    end

    // Anode classification: idle, single digit selected, or multi-hot.
    always_comb begin
        zero_cnt = 8'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (!an_sync_reg[i]) zero_cnt = zero_cnt + 8'd1;
        end
        one_hot   = (zero_cnt == 8'd1);
        multi_hot = (zero_cnt > 8'd1);
        take      = fire && one_hot;
        seen_or   = seen_reg | ~an_sync_reg;
        is_blank  = (seg_sync_reg == 7'h7F);
    end

    // Glyph table: active-low segment pattern to hex value.
    always_comb begin
        glyph_ok  = 1'b1;
        glyph_val = 4'h0;
        case (seg_sync_reg)
            7'h40: glyph_val = 4'h0;
            7'h79: glyph_val = 4'h1;
            7'h24: glyph_val = 4'h2;
            7'h30: glyph_val = 4'h3;
            7'h19: glyph_val = 4'h4;
            7'h12: glyph_val = 4'h5;
            7'h02: glyph_val = 4'h6;
            7'h78: glyph_val = 4'h7;
            7'h00: glyph_val = 4'h8;
            7'h10: glyph_val = 4'h9;
            7'h08: glyph_val = 4'hA;
            7'h03: glyph_val = 4'hB;
            7'h46: glyph_val = 4'hC;
            7'h21: glyph_val = 4'hD;
            7'h06: glyph_val = 4'hE;
            7'h0E: glyph_val = 4'hF;
            default: glyph_ok = 1'b0;
        endcase
    end

    // Per-digit capture of value, valid and blank flags.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                digit_reg[gi] <= 4'h0;
                valid_reg[gi] <= 1'b0;
                blank_reg[gi] <= 1'b0;
            end else if (clr) begin
                digit_reg[gi] <= 4'h0;
                valid_reg[gi] <= 1'b0;
                blank_reg[gi] <= 1'b0;
            end else if (take && !an_sync_reg[gi]) begin
                if (is_blank) begin
                    valid_reg[gi] <= 1'b0;
                    blank_reg[gi] <= 1'b1;
                end else if (glyph_ok) begin
                    digit_reg[gi] <= glyph_val;
                    valid_reg[gi] <= 1'b1;
                    blank_reg[gi] <= 1'b0;
                end else begin
                    valid_reg[gi] <= 1'b0;
                    blank_reg[gi] <= 1'b0;
                end
            end
        end
        assign digits[4*gi +: 4] = digit_reg[gi];
    end

    // Frame mask and single-cycle status pulses; clr wins over a sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_reg       <= '0;
            frame_done_reg <= 1'b0;
            bad_pat_reg    <= 1'b0;
            err_reg        <= 1'b0;
        end else if (clr) begin
            seen_reg       <= '0;
            frame_done_reg <= 1'b0;
            bad_pat_reg    <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            bad_pat_reg    <= 1'b0;
            err_reg        <= fire && multi_hot;
            if (take) begin
                bad_pat_reg <= !is_blank && !glyph_ok;
                if (&seen_or) begin
                    frame_done_reg <= 1'b1;
                    seen_reg       <= '0;
                end else begin
                    seen_reg <= seen_or;
                end
            end
        end
    end

    assign valid      = valid_reg;
    assign blank      = blank_reg;
    assign frame_done = frame_done_reg;
    assign bad_pat    = bad_pat_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture (NDIG=4, SETTLE=3).
module tb_seg_scan_capture;

    logic        clk;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        clr;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  blank;
    logic        frame_done;
    logic        bad_pat;
    logic        err;

    int n_cmp;
    int n_fail;
    int fd_cnt;
    int bp_cnt;
    int err_cnt;

    seg_scan_capture #(.NDIG(4), .SETTLE(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .an         (an),
        .seg        (seg),
        .clr        (clr),
        .digits     (digits),
        .valid      (valid),
        .blank      (blank),
        .frame_done (frame_done),
        .bad_pat    (bad_pat),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a bus state for n edges, tallying pulses 1 time unit after each edge.
    task automatic step(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) begin
            @(posedge clk);
            #1;
            fd_cnt  += int'(frame_done);
            bp_cnt  += int'(bad_pat);
            err_cnt += int'(err);
        end
        $display("step an=%b seg=%h n=%0d -> digits=%h valid=%b blank=%b fd=%0d bp=%0d err=%0d",
                 a, s, n, digits, valid, blank, fd_cnt, bp_cnt, err_cnt);
    endtask

    task automatic clear_counts();
        fd_cnt  = 0;
        bp_cnt  = 0;
        err_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        an    = 4'hF;
        seg   = 7'h7F;
        clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (digits !== 16'h0000) begin n_fail++; $display("FAIL reset_digits got=%h exp=%h", digits, 16'h0000); end
        n_cmp++; if (valid !== 4'h0) begin n_fail++; $display("FAIL reset_valid got=%b exp=%b", valid, 4'h0); end
        n_cmp++; if (blank !== 4'h0) begin n_fail++; $display("FAIL reset_blank got=%b exp=%b", blank, 4'h0); end
        n_cmp++; if ({frame_done, bad_pat, err} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got=%b exp=000", {frame_done, bad_pat, err}); end
        rst_n = 1'b1;
        step(4'hF, 7'h7F, 2);
    endtask

    task automatic test_scan();
        clear_counts();
        step(4'b1110, 7'h30, 8);
        step(4'b1101, 7'h0E, 8);
        step(4'b1011, 7'h40, 8);
        n_cmp++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL scan_fd_early got=%0d exp=0", fd_cnt); end
        step(4'b0111, 7'h00, 8);
        n_cmp++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL scan_fd_d3 got=%0d exp=1", fd_cnt); end
        n_cmp++; if (digits !== 16'h80F3) begin n_fail++; $display("FAIL scan_digits got=%h exp=%h", digits, 16'h80F3); end
        n_cmp++; if (valid !== 4'hF) begin n_fail++; $display("FAIL scan_valid got=%b exp=%b", valid, 4'hF); end
        n_cmp++; if (blank !== 4'h0) begin n_fail++; $display("FAIL scan_blank got=%b exp=%b", blank, 4'h0); end
        step(4'b1110, 7'h30, 8);
        step(4'b1101, 7'h0E, 8);
        step(4'b1011, 7'h40, 8);
        step(4'b0111, 7'h00, 8);
        n_cmp++; if (fd_cnt !== 2) begin n_fail++; $display("FAIL scan_fd_second got=%0d exp=2", fd_cnt); end
        n_cmp++; if ({bp_cnt, err_cnt} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL scan_other_pulses got=%0d/%0d exp=0/0", bp_cnt, err_cnt); end
    endtask

    task automatic test_glitch();
        clear_counts();
        step(4'b1110, 7'h24, 3);
        n_cmp++; if (digits[3:0] !== 4'h3) begin n_fail++; $display("FAIL glitch_short got=%h exp=%h", digits[3:0], 4'h3); end
        step(4'b1110, 7'h19, 3);
        n_cmp++; if (digits[3:0] !== 4'h3) begin n_fail++; $display("FAIL glitch_latency_early got=%h exp=%h", digits[3:0], 4'h3); end
        step(4'b1110, 7'h19, 1);
        n_cmp++; if (digits[3:0] !== 4'h4) begin n_fail++; $display("FAIL glitch_latency got=%h exp=%h", digits[3:0], 4'h4); end
        step(4'b1110, 7'h19, 4);
        n_cmp++; if (digits !== 16'h80F4) begin n_fail++; $display("FAIL glitch_digits got=%h exp=%h", digits, 16'h80F4); end
        n_cmp++; if (fd_cnt + bp_cnt + err_cnt !== 0) begin n_fail++; $display("FAIL glitch_pulses got=%0d exp=0", fd_cnt + bp_cnt + err_cnt); end
    endtask

    task automatic test_blank_illegal();
        clear_counts();
        step(4'b1101, 7'h7F, 8);
        n_cmp++; if ({blank[1], valid[1]} !== 2'b10) begin n_fail++; $display("FAIL blank_flags got=%b exp=10", {blank[1], valid[1]}); end
        n_cmp++; if (digits[7:4] !== 4'hF) begin n_fail++; $display("FAIL blank_keep got=%h exp=%h", digits[7:4], 4'hF); end
        step(4'b1101, 7'h55, 8);
        n_cmp++; if (bp_cnt !== 1) begin n_fail++; $display("FAIL illegal_bp got=%0d exp=1", bp_cnt); end
        n_cmp++; if ({blank[1], valid[1]} !== 2'b00) begin n_fail++; $display("FAIL illegal_flags got=%b exp=00", {blank[1], valid[1]}); end
        n_cmp++; if (digits[7:4] !== 4'hF) begin n_fail++; $display("FAIL illegal_keep got=%h exp=%h", digits[7:4], 4'hF); end
        n_cmp++; if (fd_cnt + err_cnt !== 0) begin n_fail++; $display("FAIL illegal_other got=%0d exp=0", fd_cnt + err_cnt); end
    endtask

    task automatic test_multi_hot();
        clear_counts();
        step(4'b1100, 7'h79, 8);
        n_cmp++; if (err_cnt !== 1) begin n_fail++; $display("FAIL multi_err got=%0d exp=1", err_cnt); end
        n_cmp++; if (digits !== 16'h80F4) begin n_fail++; $display("FAIL multi_digits got=%h exp=%h", digits, 16'h80F4); end
        n_cmp++; if (valid !== 4'b1101) begin n_fail++; $display("FAIL multi_valid got=%b exp=%b", valid, 4'b1101); end
        n_cmp++; if (fd_cnt + bp_cnt !== 0) begin n_fail++; $display("FAIL multi_other got=%0d exp=0", fd_cnt + bp_cnt); end
        // digits 0 and 1 already seen: 2 then 3 completes the frame
        step(4'b1011, 7'h40, 8);
        n_cmp++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL multi_frame_early got=%0d exp=0", fd_cnt); end
        step(4'b0111, 7'h00, 8);
        n_cmp++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL multi_frame got=%0d exp=1", fd_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        step(4'b1110, 7'h30, 8);
        step(4'b1101, 7'h0E, 8);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({digits, valid, blank} !== 24'h0) begin n_fail++; $display("FAIL rstmid_async got=%h exp=0", {digits, valid, blank}); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b1101, 7'h0E, 3);
        n_cmp++; if (digits !== 16'h0000) begin n_fail++; $display("FAIL rstmid_settle got=%h exp=%h", digits, 16'h0000); end
        step(4'b1101, 7'h0E, 5);
        n_cmp++; if (digits !== 16'h00F0) begin n_fail++; $display("FAIL rstmid_d1 got=%h exp=%h", digits, 16'h00F0); end
        step(4'b1011, 7'h40, 8);
        step(4'b0111, 7'h00, 8);
        n_cmp++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL rstmid_fd_early got=%0d exp=0", fd_cnt); end
        step(4'b1110, 7'h30, 8);
        n_cmp++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL rstmid_fd got=%0d exp=1", fd_cnt); end
    endtask

    task automatic test_clr_collision();
        clear_counts();
        step(4'b1110, 7'h30, 8);
        step(4'b1101, 7'h0E, 8);
        step(4'b1011, 7'h40, 8);
        step(4'b0111, 7'h00, 3);
        clr = 1'b1;
        step(4'b0111, 7'h00, 1);
        clr = 1'b0;
        step(4'b0111, 7'h00, 4);
        n_cmp++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL clr_fd got=%0d exp=0", fd_cnt); end
        n_cmp++; if (digits !== 16'h0000) begin n_fail++; $display("FAIL clr_digits got=%h exp=%h", digits, 16'h0000); end
        n_cmp++; if (valid !== 4'h0) begin n_fail++; $display("FAIL clr_valid got=%b exp=%b", valid, 4'h0); end
        step(4'b1110, 7'h30, 8);
        step(4'b1101, 7'h0E, 8);
        step(4'b1011, 7'h40, 8);
        n_cmp++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL clr_mask_early got=%0d exp=0", fd_cnt); end
        step(4'b0111, 7'h00, 8);
        n_cmp++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL clr_mask_frame got=%0d exp=1", fd_cnt); end
        n_cmp++; if (digits !== 16'h80F3) begin n_fail++; $display("FAIL clr_rescan got=%h exp=%h", digits, 16'h80F3); end
    endtask

    task automatic test_glyphs();
        logic [6:0] glyph [16];
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        clear_counts();
        for (int i = 0; i < 16; i++) begin
            step(4'b1110, glyph[i], 5);
            n_cmp++;
            if ({valid[0], digits[3:0]} !== {1'b1, 4'(i)}) begin
                n_fail++;
                $display("FAIL glyph_%0d got=%b/%h exp=1/%h", i, valid[0], digits[3:0], 4'(i));
            end
        end
        n_cmp++; if (bp_cnt !== 0) begin n_fail++; $display("FAIL glyph_bp got=%0d exp=0", bp_cnt); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        clear_counts();
        test_reset();
        test_scan();
        test_glitch();
        test_blank_illegal();
        test_multi_hot();
        test_reset_mid();
        test_clr_collision();
        test_glyphs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Receive-side companion to the display encoder. It watches the time-multiplexed anode/segment bus that drives the Basys3 four-digit seven-segment display and recovers the 4-bit hex value shown on each digit. It flags blank digits, illegal patterns and bad anode drive, and signals completed scan frames. It sits beside the display driver as a self-check and loopback monitor for the counter datapath.

## Interface
Parameters:
- NDIG, 4, number of multiplexed digits; anode bus width.
- SETTLE, 3, consecutive stable clock edges required before a bus state is sampled; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- an  in  NDIG  anode bus, active-low; an[k]=0 selects digit k.
- seg  in  7  cathode bus, active-low; seg[0]=a … seg[6]=g.
- clr  in  1  synchronous clear of captured state.
- digits  out  4*NDIG  recovered values; digits[4k+3:4k] is digit k.
- valid  out  NDIG  valid[k]=1 when digit k's last sample decoded to a legal hex glyph.
- blank  out  NDIG  blank[k]=1 when digit k's last sample was all segments off (seg=7'h7F).
- frame_done  out  1  one-cycle pulse when every digit has been sampled since the last frame.
- bad_pat  out  1  one-cycle pulse when a selected digit shows an undecodable pattern.
- err  out  1  one-cycle pulse when more than one anode is driven low.

## Operation
- Input stage: an and seg are registered once (sync stage) before any use.
- Dwell detection: a counter of width clog2(SETTLE+1) compares the registered {an,seg} with its previous value.
  - Mismatch: the counter is set to 0 and the sampled flag is cleared.
  - Match: the counter increments, saturating at SETTLE.
- Sampling: the counter reaching SETTLE with the sampled flag clear causes exactly one sample for that dwell; the sampled flag then sets.
- Sample decode, with an = registered anode value:
  - all ones: idle. No state update, no pulse.
  - exactly one zero at index k: digit k is marked seen.
    - seg=7'h7F: blank[k]=1, valid[k]=0, digits[k] unchanged.
    - seg matches the glyph table: digits[k]=value, valid[k]=1, blank[k]=0.
    - seg is any other pattern: valid[k]=0, blank[k]=0, digits[k] unchanged, bad_pat pulses.
  - two or more zeros: err pulses. No update, no seen marking.
- Glyph table, seg value (hex) → digit:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - Any pattern not in this list is illegal.
- Frame tracking: an NDIG-bit seen mask accumulates.
  - When a sample makes the mask all ones, frame_done pulses and the mask clears on the same edge.
  - Re-sampling an already-seen digit overwrites its value and does not pulse frame_done.
- clr: clears digits, valid, blank, seen mask and any pending pulse. clr has priority over a sample on the same edge. The dwell counter is not affected.

## Timing
- Reset values: digits=0, valid=0, blank=0, frame_done=0, bad_pat=0, err=0, seen mask=0, dwell counter=0, sampled flag=0. The sync registers reset to an=all ones and seg=7'h7F.
- Latency: when a new an/seg value is present before edge E and held, the sync stage captures it at E. Outputs and pulses update at edge E+SETTLE, so SETTLE+1 edges from the input change.
- Short dwells: a dwell held for fewer than SETTLE+1 edges produces no sample and no pulse.
- Pulse shape: frame_done, bad_pat and err are registered and high for exactly one cycle per qualifying sample.
- Reset mid-frame: asserting rst_n low immediately forces all reset values, including during a dwell. After release, a bus value already stable requires a full SETTLE+1 edges before it is sampled.

## Test plan
- Round-robin scan, 8 cycles per digit: an=1110/seg 30, 1101/seg 0E, 1011/seg 40, 0111/seg 00 → digits=16'h80F3, valid=4'hF, blank=0. frame_done pulses once per scan, on the sample of digit 3.
- Glitch rejection with SETTLE=3: hold an=1110, seg=24 for 3 edges, then 1110/19 for 8 edges → digit0 becomes 4, never 2. No pulses.
- Blank and illegal patterns: an=1101/seg 7F → blank[1]=1, valid[1]=0. Then an=1101/seg 55 → bad_pat single pulse, blank[1]=0, digits[7:4] unchanged.
- Multi-hot anode: an=1100/seg 79 held 8 cycles → err pulses once, all outputs unchanged, no frame progress.
- Reset mid-frame: sample digits 0 and 1, then assert rst_n low for one cycle → all outputs 0. A subsequent full scan needs all four digits before frame_done pulses.
- clr collision: assert clr on the edge where digit 3 would complete a frame → no frame_done, digits=0, valid=0. The mask restarts from empty.
